// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisor helper and the
// three-sample majority vote used by the optional oversampling front end.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  function automatic int unsigned clks_per_baud(input int unsigned clk_rate,
                                                input int unsigned baud);
    return clk_rate / baud;
  endfunction

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter with synchronous clear; flags the in-bit sample point and
// the last clock of each bit period. Shared by the UART receiver and transmitter.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BAUD = 1250,
  parameter int unsigned MID_POINT     = 624
) (
  input  logic clk,
  input  logic n_reset,
  input  logic i_clear,
  output logic o_mid_tick,
  output logic o_end_tick
);

  localparam int unsigned CW = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BAUD - 1);
  localparam logic [CW-1:0] MID  = CW'(MID_POINT);

  logic [CW-1:0] r_count;

  // Free-running modulo-CLKS_PER_BAUD counter, restartable by i_clear.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_count <= '0;
    end else if (i_clear || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign o_mid_tick = (r_count == MID);
  assign o_end_tick = (r_count == LAST);

endmodule

// File: rtl/uart_rx_stage.sv
// UART receiver: 2-flop synchroniser, frame FSM and valid/ready byte output.
// Define UART_RX_MAJORITY_EN to vote each bit over three consecutive rx_s samples.
module uart_rx_stage
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned CLK_RATE   = 12_000_000
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  uart_rx_pin,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  framing_error,
  output logic                  overrun
);

  localparam int unsigned CPB  = clks_per_baud(CLK_RATE, BAUD);
  localparam int unsigned IDXW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(DATA_WIDTH - 1);
  localparam logic [1:0]      LAST_STOP = 2'(STOP_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  // The vote needs one sample past the mid-bit point, so the decision moves one clock later.
  localparam int unsigned MID_POINT = CPB / 2;
`else
  localparam int unsigned MID_POINT = CPB / 2 - 1;
`endif

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  w_rx_s;
  logic                  w_sample;
  logic                  w_mid_tick;
  logic                  w_end_tick;
  logic                  w_clear;
  logic                  w_deliver;
  logic                  w_ferr;
  uart_rx_state_t        r_state;
  uart_rx_state_t        w_state_next;
  logic [IDXW-1:0]       r_idx;
  logic [IDXW-1:0]       w_idx_next;
  logic [1:0]            r_stop_cnt;
  logic [1:0]            w_stop_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_ferr;
  logic                  r_ovr;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  // History of the two previous rx_s values for the three-sample vote.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign w_sample = majority3({r_hist[1], r_hist[0], w_rx_s});
`else
  assign w_sample = w_rx_s;
`endif

  uart_baud_tick #(
    .CLKS_PER_BAUD (CPB),
    .MID_POINT     (MID_POINT)
  ) u_baud_tick (
    .clk        (clk),
    .n_reset    (n_reset),
    .i_clear    (w_clear),
    .o_mid_tick (w_mid_tick),
    .o_end_tick (w_end_tick)
  );

  // Frame FSM state, bit index, stop-bit count and shift register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_stop_cnt <= 2'd0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_stop_cnt <= w_stop_next;
      r_shift    <= w_shift_next;
    end
  end

  // Next-state logic; after the start-bit re-centre, DATA/STOP sample once per bit period.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_stop_next  = r_stop_cnt;
    w_shift_next = r_shift;
    w_clear      = 1'b0;
    w_deliver    = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (!w_rx_s) begin
          w_state_next = START;
        end else begin
          w_state_next = IDLE;
        end
      end
      START: begin
        if (w_mid_tick) begin
          w_clear = 1'b1;
          if (!w_sample) begin
            w_state_next = DATA;
            w_idx_next   = '0;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_state_next = START;
        end
      end
      DATA: begin
        if (w_end_tick) begin
          w_shift_next[r_idx] = w_sample;
          if (r_idx == LAST_IDX) begin
            w_state_next = STOP;
            w_stop_next  = 2'd0;
          end else begin
            w_idx_next = r_idx + {{(IDXW-1){1'b0}}, 1'b1};
          end
        end else begin
          w_state_next = DATA;
        end
      end
      STOP: begin
        if (w_end_tick) begin
          if (!w_sample) begin
            w_ferr       = 1'b1;
            w_state_next = BREAK;
          end else if (r_stop_cnt == LAST_STOP) begin
            w_deliver    = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_stop_next = r_stop_cnt + 2'd1;
          end
        end else begin
          w_state_next = STOP;
        end
      end
      BREAK: begin
        if (w_rx_s) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = BREAK;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Output stream register: a completed byte is dropped with an overrun pulse if the held one is not taken.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || m_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (m_ready) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign m_data        = r_data;
  assign m_valid       = r_valid;
  assign framing_error = r_ferr;
  assign overrun       = r_ovr;

endmodule

// File: tb/tb_uart_rx_stage.sv
// Directed bench for uart_rx_stage at 16 clocks per bit; a UART line model drives frames
// and a negedge monitor collects accepted bytes and error pulses.
`timescale 1ns/1ps
module tb_uart_rx_stage;

  localparam int unsigned CLK_RATE = 12_000_000;
  localparam int unsigned BAUD     = 750_000;
  localparam int          CPB      = 16;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       uart_rx_pin = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       framing_error;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always #42 clk = ~clk;

  uart_rx_stage #(
    .DATA_WIDTH (8),
    .STOP_BITS  (1),
    .BAUD       (BAUD),
    .CLK_RATE   (CLK_RATE)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .uart_rx_pin   (uart_rx_pin),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always @(negedge clk) begin
    if (m_valid && m_ready) rx_q.push_back(m_data);
    if (framing_error) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (framing_error && overrun) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_bit(input logic lvl, input int glitch_at);
    for (int t = 0; t < CPB; t++) begin
      uart_rx_pin = (t == glitch_at) ? 1'b0 : lvl;
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int glitch_bit);
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(b[i], (i == glitch_bit) ? CPB / 2 : -1);
    drive_bit(stop_lvl, -1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
  endtask

  initial begin
    logic [7:0] b;
    int n_rand;

    // Reset values
    #5;
    check("rst_data", {24'd0, m_data}, 32'h0);
    check("rst_valid", {31'd0, m_valid}, 32'h0);
    check("rst_ferr", {31'd0, framing_error}, 32'h0);
    check("rst_ovr", {31'd0, overrun}, 32'h0);
    ticks(3);
    n_reset = 1'b1;
    ticks(CPB);

    // 0x00 then 0xFF with consumer always ready
    m_ready = 1'b1;
    clear_mon();
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    ticks(CPB);
    check("edge_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("edge_b0", {24'd0, rx_q[0]}, 32'h00);
      check("edge_b1", {24'd0, rx_q[1]}, 32'hFF);
    end
    check("edge_ferr", ferr_cnt, 0);
    check("edge_ovr", ovr_cnt, 0);

    // Random stream with short random idle gaps
    clear_mon();
    exp_q.delete();
    n_rand = 60;
    for (int k = 0; k < n_rand; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1, -1);
      ticks($urandom_range(0, 8));
    end
    ticks(CPB);
    check("rand_count", rx_q.size(), n_rand);
    for (int k = 0; k < n_rand; k++) begin
      if (k < rx_q.size()) check($sformatf("rand_b%0d", k), {24'd0, rx_q[k]}, {24'd0, exp_q[k]});
    end
    check("rand_ferr", ferr_cnt, 0);
    check("rand_ovr", ovr_cnt, 0);

    // 0.4-bit low glitch on the idle line is ignored
    clear_mon();
    uart_rx_pin = 1'b0;
    ticks(6);
    uart_rx_pin = 1'b1;
    ticks(3 * CPB);
    check("glitch_novalid", rx_q.size(), 0);
    check("glitch_noferr", ferr_cnt, 0);
    send_frame(8'hA5, 1'b1, -1);
    ticks(CPB);
    check("glitch_next_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("glitch_next_b", {24'd0, rx_q[0]}, 32'hA5);

    // Low stop bit followed by a held-low line: one framing error, then recovery
    clear_mon();
    send_frame(8'h3C, 1'b0, -1);
    ticks(5 * CPB);
    uart_rx_pin = 1'b1;
    ticks(CPB);
    check("brk_ferr", ferr_cnt, 1);
    check("brk_novalid", rx_q.size(), 0);
    check("brk_valid_low", {31'd0, m_valid}, 32'h0);
    send_frame(8'h3C, 1'b1, -1);
    ticks(CPB);
    check("brk_next_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("brk_next_b", {24'd0, rx_q[0]}, 32'h3C);
    check("brk_ferr_after", ferr_cnt, 1);

    // Back-pressure: second byte overruns, first byte held
    clear_mon();
    m_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    check("ovr_first_valid", {31'd0, m_valid}, 32'h1);
    check("ovr_first_data", {24'd0, m_data}, 32'h11);
    check("ovr_none_yet", ovr_cnt, 0);
    send_frame(8'h22, 1'b1, -1);
    ticks(CPB);
    check("ovr_count", ovr_cnt, 1);
    check("ovr_hold_data", {24'd0, m_data}, 32'h11);
    check("ovr_hold_valid", {31'd0, m_valid}, 32'h1);
    check("ovr_ferr", ferr_cnt, 0);
    m_ready = 1'b1;
    check("ovr_before_accept", {31'd0, m_valid}, 32'h1);
    tick();
    check("ovr_after_accept", {31'd0, m_valid}, 32'h0);
    check("ovr_accept_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("ovr_accept_b", {24'd0, rx_q[0]}, 32'h11);

    // Reset in the middle of DATA aborts the frame
    check("pre_reset_data", {24'd0, m_data}, 32'h11);
    clear_mon();
    b = 8'h55;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 3; i++) drive_bit(b[i], -1);
    uart_rx_pin = b[3];
    ticks(CPB / 2);
    n_reset = 1'b0;
    #1;
    check("midrst_data", {24'd0, m_data}, 32'h0);
    check("midrst_valid", {31'd0, m_valid}, 32'h0);
    check("midrst_ferr", {31'd0, framing_error}, 32'h0);
    check("midrst_ovr", {31'd0, overrun}, 32'h0);
    uart_rx_pin = 1'b1;
    ticks(3);
    n_reset = 1'b1;
    ticks(CPB);
    send_frame(8'h96, 1'b1, -1);
    ticks(2 * CPB);
    check("midrst_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("midrst_b", {24'd0, rx_q[0]}, 32'h96);
    check("midrst_ferr_cnt", ferr_cnt, 0);

`ifdef UART_RX_MAJORITY_EN
    // One-clock low glitch at the centre of a '1' data bit is voted out
    clear_mon();
    send_frame(8'hB7, 1'b1, 2);
    ticks(CPB);
    check("maj_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("maj_b", {24'd0, rx_q[0]}, 32'hB7);
    check("maj_ferr", ferr_cnt, 0);
`endif

    check("never_both", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
